// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: loads win, displaced ALU results
// queue in order and back-pressure the ALU when the queue is full.
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_value,
  output logic             alu_stall,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_value,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_value,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      q_rd  [DEPTH];
  logic [XLEN-1:0] q_val [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] vld_n;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     busy_n;

  logic mem_req;
  logic alu_w;
  logic fifo_ne;
  logic pop;
  logic push;
  logic bypass;

  assign alu_stall = (count == CW'(DEPTH));
  assign mem_req   = mem_valid && (mem_rd != 5'd0);
  assign alu_w     = alu_valid && !alu_stall
                     && (alu_rd != 5'd0);
  assign fifo_ne   = (count != '0);
  assign pop       = !mem_req && fifo_ne;
  assign bypass    = !mem_req && !fifo_ne && alu_w;
  assign push      = alu_w && (mem_req || fifo_ne);

  // busy_mask is registered from the post-edge queue contents
  always_comb begin
    vld_n = q_vld;
    if (pop)
      vld_n[rd_ptr] = 1'b0;
    if (push)
      vld_n[wr_ptr] = 1'b1;
  end

  always_comb begin
    busy_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_n[i]) begin
        if (push && (PW'(i) == wr_ptr))
          busy_n[alu_rd] = 1'b1;
        else
          busy_n[q_rd[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_rd[wr_ptr]  <= alu_rd;
      q_val[wr_ptr] <= alu_value;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wb_en        <= 1'b0;
      wb_rd        <= '0;
      wb_value     <= '0;
      q_vld        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      busy_mask    <= '0;
      conflict_cnt <= '0;
    end else begin
      unique case (1'b1)
        mem_req: begin
          wb_en    <= 1'b1;
          wb_rd    <= mem_rd;
          wb_value <= mem_value;
        end
        pop: begin
          wb_en    <= 1'b1;
          wb_rd    <= q_rd[rd_ptr];
          wb_value <= q_val[rd_ptr];
        end
        bypass: begin
          wb_en    <= 1'b1;
          wb_rd    <= alu_rd;
          wb_value <= alu_value;
        end
        default: wb_en <= 1'b0;
      endcase

      q_vld     <= vld_n;
      busy_mask <= busy_n;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (push && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
